// File: rtl/nn_cfg_pkg.sv
// Shared types and defaults for the NN configuration sequencer.
// Optional feature macro: NN_CFG_ERRCNT_EN (error counter / last error code).
package nn_cfg_pkg;

  localparam int NUM_LAYERS_D  = 3;
  localparam int NUM_NEURONS_D = 30;
  localparam int NUM_WEIGHTS_D = 784;
  localparam int DATA_WIDTH_D  = 16;

  localparam int AW_D = $clog2(NUM_WEIGHTS_D);
  localparam int LW_D = $clog2(NUM_LAYERS_D + 1);
  localparam int NW_D = $clog2(NUM_NEURONS_D);

  typedef enum logic [1:0] {
    UNSEL,
    READY,
    LOADING,
    FULL
  } cfg_state_t;

  localparam logic [1:0] ERR_OVF   = 2'd0;
  localparam logic [1:0] ERR_UNSEL = 2'd1;
  localparam logic [1:0] ERR_BUSY  = 2'd2;
  localparam logic [1:0] ERR_COLL  = 2'd3;

  localparam logic [7:0] REG_WEIGHT = 8'h00;
  localparam logic [7:0] REG_BIAS   = 8'h04;
  localparam logic [7:0] REG_LAYER  = 8'h0C;
  localparam logic [7:0] REG_NEURON = 8'h10;

endpackage

// File: rtl/nn_cfg_donemap.sv
// Per-neuron weight/bias completion bitmaps with registered all-done flag.
// Layers are numbered from 1, so the layer index is offset by one.
module nn_cfg_donemap
  import nn_cfg_pkg::*;
#(
  parameter int NUM_LAYERS  = NUM_LAYERS_D,
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  parameter int LW          = LW_D,
  parameter int NW          = NW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_set,
  input  logic          b_set,
  input  logic [LW-1:0] layer,
  input  logic [NW-1:0] neuron,
  output logic          done
);

  logic [NUM_LAYERS-1:0][NUM_NEURONS-1:0] wmap;
  logic [NUM_LAYERS-1:0][NUM_NEURONS-1:0] bmap;
  logic [LW-1:0] li;

  assign li = layer - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wmap <= '0;
      bmap <= '0;
      done <= 1'b0;
    end else begin
      if (w_set) wmap[li][neuron] <= 1'b1;
      if (b_set) bmap[li][neuron] <= 1'b1;
      done <= (&wmap) && (&bmap);
    end
  end

endmodule

// File: rtl/nn_cfg_sequencer.sv
// Turns register-write strobes into addressed weight/bias memory beats.
// Optional feature macro: NN_CFG_ERRCNT_EN adds err_count and last_err.
module nn_cfg_sequencer
  import nn_cfg_pkg::*;
#(
  parameter int NUM_LAYERS  = NUM_LAYERS_D,
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  parameter int NUM_WEIGHTS = NUM_WEIGHTS_D,
  parameter int DATA_WIDTH  = DATA_WIDTH_D,
  localparam int AW = $clog2(NUM_WEIGHTS),
  localparam int CW = $clog2(NUM_WEIGHTS + 1),
  localparam int LW = $clog2(NUM_LAYERS + 1),
  localparam int NW = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_wr,
  input  logic                  neuron_wr,
  input  logic                  weight_wr,
  input  logic                  bias_wr,
  input  logic [31:0]           wr_data,
  input  logic                  infer_busy,
  input  logic                  err_clr,
`ifdef NN_CFG_ERRCNT_EN
  output logic [15:0]           err_count,
  output logic [1:0]            last_err,
`endif
  output logic                  w_valid,
  output logic [AW-1:0]         w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  b_valid,
  output logic [31:0]           b_data,
  output logic [LW-1:0]         sel_layer,
  output logic [NW-1:0]         sel_neuron,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  cfg_state_t    state;
  logic [CW-1:0] cnt;
  logic          lay_ok, neu_ok;
  logic          do_l, do_n, do_b, do_w;
  logic          b_ok, w_ok, w_last, coll, err_now;
  logic [2:0]    nstrb, ndrop;
  logic [1:0]    code;
  logic          l_rng, n_rng;

  assign nstrb = {2'b0, layer_wr} + {2'b0, neuron_wr}
               + {2'b0, weight_wr} + {2'b0, bias_wr};
  assign coll  = nstrb > 3'd1;
  assign l_rng = (wr_data >= 32'd1) && (wr_data <= 32'(NUM_LAYERS));
  assign n_rng = wr_data < 32'(NUM_NEURONS);

  // Strobe priority: layer > neuron > bias > weight
  always_comb begin
    do_l   = !infer_busy && layer_wr;
    do_n   = !infer_busy && !layer_wr && neuron_wr;
    do_b   = !infer_busy && !layer_wr && !neuron_wr && bias_wr;
    do_w   = !infer_busy && !layer_wr && !neuron_wr && !bias_wr
             && weight_wr;
    b_ok   = do_b && (state != UNSEL);
    w_ok   = do_w && (state == READY || state == LOADING);
    w_last = w_ok && (cnt == CW'(NUM_WEIGHTS - 1));
    err_now = (infer_busy && nstrb != 3'd0) || coll
              || (do_b && !b_ok) || (do_w && !w_ok);
    ndrop = 3'd0;
    code  = ERR_COLL;
    if (coll) ndrop = nstrb - 3'd1;
    if ((do_b && !b_ok) || (do_w && !w_ok)) begin
      ndrop = ndrop + 3'd1;
      code  = (do_w && state == FULL) ? ERR_OVF : ERR_UNSEL;
    end
    if (infer_busy) begin
      ndrop = nstrb;
      code  = ERR_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNSEL;
      cnt        <= '0;
      lay_ok     <= 1'b0;
      neu_ok     <= 1'b1;
      w_valid    <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      b_valid    <= 1'b0;
      b_data     <= '0;
      sel_layer  <= '0;
      sel_neuron <= '0;
      cfg_err    <= 1'b0;
    end else begin
      w_valid <= w_ok;
      b_valid <= b_ok;
      if (w_ok) begin
        w_addr <= cnt[AW-1:0];
        w_data <= wr_data[DATA_WIDTH-1:0];
        cnt    <= cnt + 1'b1;
        state  <= w_last ? FULL : LOADING;
      end
      if (b_ok) b_data <= wr_data;
      if (do_l) begin
        sel_layer <= wr_data[LW-1:0];
        lay_ok    <= l_rng;
        cnt       <= '0;
        state     <= (l_rng && neu_ok) ? READY : UNSEL;
      end
      if (do_n) begin
        sel_neuron <= wr_data[NW-1:0];
        neu_ok     <= n_rng;
        cnt        <= '0;
        state      <= (n_rng && lay_ok) ? READY : UNSEL;
      end
      if (err_now)      cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
    end
  end

`ifdef NN_CFG_ERRCNT_EN
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, err_count} + {14'b0, ndrop};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      last_err  <= ERR_OVF;
    end else begin
      if (err_now) begin
        err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        last_err  <= code;
      end else if (err_clr) begin
        err_count <= '0;
      end
    end
  end
`else
  logic unused_err;
  assign unused_err = ^{ndrop, code};
`endif

  nn_cfg_donemap #(
    .NUM_LAYERS  (NUM_LAYERS),
    .NUM_NEURONS (NUM_NEURONS),
    .LW          (LW),
    .NW          (NW)
  ) u_donemap (
    .clk    (clk),
    .rst    (rst),
    .w_set  (w_last),
    .b_set  (b_ok),
    .layer  (sel_layer),
    .neuron (sel_neuron),
    .done   (cfg_done)
  );

endmodule

// File: tb/tb_nn_cfg_sequencer.sv
// Directed bench for nn_cfg_sequencer with hand-computed expectations.
// Optional feature macro: NN_CFG_ERRCNT_EN enables err_count/last_err checks.
module tb_nn_cfg_sequencer;
  import nn_cfg_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic        layer_wr = 0, neuron_wr = 0;
  logic        weight_wr = 0, bias_wr = 0;
  logic [31:0] wr_data = 0;
  logic        infer_busy = 0, err_clr = 0;
  logic        w_valid, b_valid, cfg_done, cfg_err;
  logic [9:0]  w_addr;
  logic [15:0] w_data;
  logic [31:0] b_data;
  logic [1:0]  sel_layer;
  logic [4:0]  sel_neuron;
`ifdef NN_CFG_ERRCNT_EN
  logic [15:0] err_count;
  logic [1:0]  last_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nn_cfg_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .layer_wr   (layer_wr),
    .neuron_wr  (neuron_wr),
    .weight_wr  (weight_wr),
    .bias_wr    (bias_wr),
    .wr_data    (wr_data),
    .infer_busy (infer_busy),
    .err_clr    (err_clr),
`ifdef NN_CFG_ERRCNT_EN
    .err_count  (err_count),
    .last_err   (last_err),
`endif
    .w_valid    (w_valid),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .sel_layer  (sel_layer),
    .sel_neuron (sel_neuron),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs for it are visible on return
  task automatic step(input logic l, input logic n,
                      input logic w, input logic b,
                      input logic [31:0] d,
                      input logic busy = 0, input logic clr = 0);
    @(negedge clk);
    layer_wr = l; neuron_wr = n; weight_wr = w; bias_wr = b;
    wr_data = d; infer_busy = busy; err_clr = clr;
    @(posedge clk);
    #1;
    layer_wr = 0; neuron_wr = 0; weight_wr = 0; bias_wr = 0;
    infer_busy = 0; err_clr = 0;
  endtask

  task automatic sel(input int l, input int n);
    step(1, 0, 0, 0, 32'(l));
    step(0, 1, 0, 0, 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".w_valid"}, 32'(w_valid), 0);
    check({tag, ".w_addr"}, 32'(w_addr), 0);
    check({tag, ".w_data"}, 32'(w_data), 0);
    check({tag, ".b_valid"}, 32'(b_valid), 0);
    check({tag, ".b_data"}, b_data, 0);
    check({tag, ".sel_layer"}, 32'(sel_layer), 0);
    check({tag, ".sel_neuron"}, 32'(sel_neuron), 0);
    check({tag, ".cfg_done"}, 32'(cfg_done), 0);
    check({tag, ".cfg_err"}, 32'(cfg_err), 0);
    check({tag, ".state"}, 32'(dut.state), 32'(UNSEL));
  endtask

  initial begin
    int bad;

    do_reset();
    check_zero("reset");
    @(negedge clk);
    rst = 0;

    // Full load of layer 1 neuron 0, then overflow
    sel(1, 0);
    check("sel.w_valid", 32'(w_valid), 0);
    check("sel.state", 32'(dut.state), 32'(READY));
    bad = 0;
    for (int i = 0; i < 784; i++) begin
      step(0, 0, 1, 0, 32'(i));
      if (!w_valid || w_addr != 10'(i) || w_data != 16'(i)) bad++;
    end
    check("load.beats_bad", 32'(bad), 0);
    check("load.last_addr", 32'(w_addr), 783);
    check("load.state", 32'(dut.state), 32'(FULL));
    check("load.cfg_err", 32'(cfg_err), 0);
    step(0, 0, 1, 0, 32'h55);
    check("ovf.w_valid", 32'(w_valid), 0);
    check("ovf.cfg_err", 32'(cfg_err), 1);
`ifdef NN_CFG_ERRCNT_EN
    check("ovf.last_err", 32'(last_err), 32'(ERR_OVF));
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    check("clr.cfg_err", 32'(cfg_err), 0);

    // Invalid layer, then valid bias
    step(1, 0, 0, 0, 32'd4);
    step(0, 0, 1, 0, 32'd9);
    check("badlay.w_valid", 32'(w_valid), 0);
    check("badlay.cfg_err", 32'(cfg_err), 1);
    check("badlay.state", 32'(dut.state), 32'(UNSEL));
    sel(2, 29);
    step(0, 0, 0, 1, 32'h1234);
    check("bias.b_valid", 32'(b_valid), 1);
    check("bias.b_data", b_data, 32'h1234);
    check("bias.sel_layer", 32'(sel_layer), 2);
    check("bias.sel_neuron", 32'(sel_neuron), 29);
    check("bias.state", 32'(dut.state), 32'(READY));
    step(0, 0, 0, 0, 0);
    check("bias.pulse", 32'(b_valid), 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Busy during push at address 100
    sel(1, 5);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 32'(i));
    check("busy.pre_addr", 32'(w_addr), 99);
    step(0, 0, 1, 0, 32'hAA, 1);
    check("busy.w_valid", 32'(w_valid), 0);
    check("busy.cfg_err", 32'(cfg_err), 1);
    step(0, 0, 1, 0, 32'hBB);
    check("busy.post_valid", 32'(w_valid), 1);
    check("busy.post_addr", 32'(w_addr), 100);
    check("busy.post_data", 32'(w_data), 32'hBB);
    step(0, 0, 0, 0, 0, 0, 1);
    check("busy.clr", 32'(cfg_err), 0);

    // Neuron + weight collision
    step(0, 1, 1, 0, 32'd7);
    check("coll.sel_neuron", 32'(sel_neuron), 7);
    check("coll.w_valid", 32'(w_valid), 0);
    check("coll.cfg_err", 32'(cfg_err), 1);
`ifdef NN_CFG_ERRCNT_EN
    check("coll.err_count", 32'(err_count), 1);
    check("coll.last_err", 32'(last_err), 32'(ERR_COLL));
`endif
    step(0, 0, 1, 0, 32'h3);
    check("coll.next_addr", 32'(w_addr), 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Load every neuron; done rises one cycle after the last bias
    for (int l = 1; l <= 3; l++) begin
      for (int n = 0; n < 30; n++) begin
        sel(l, n);
        for (int i = 0; i < 784; i++) step(0, 0, 1, 0, 32'(i + n));
        step(0, 0, 0, 1, 32'(l * 100 + n));
      end
    end
    check("all.b_valid", 32'(b_valid), 1);
    check("all.b_data", b_data, 32'd329);
    check("all.done_early", 32'(cfg_done), 0);
    step(0, 0, 0, 0, 0);
    check("all.cfg_done", 32'(cfg_done), 1);
    check("all.cfg_err", 32'(cfg_err), 0);

    // Reset mid-load
    sel(3, 3);
    for (int i = 0; i < 400; i++) step(0, 0, 1, 0, 32'(i));
    check("mid.addr", 32'(w_addr), 399);
    do_reset();
    check_zero("midrst");
    @(negedge clk);
    rst = 0;
    sel(1, 0);
    step(0, 0, 1, 0, 32'h77);
    check("rel.first_valid", 32'(w_valid), 1);
    check("rel.first_addr", 32'(w_addr), 0);
    for (int i = 1; i < 784; i++) step(0, 0, 1, 0, 32'(i));
    check("rel.last_addr", 32'(w_addr), 783);
    check("rel.state", 32'(dut.state), 32'(FULL));
    step(0, 0, 0, 0, 0);
    check("rel.cfg_done", 32'(cfg_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
